// File: rtl/gci_std_display_rect_fill.sv
// gci_std_display_rect_fill
// Solid rectangle / full-screen fill engine. Accepts one command at a time,
// clips the rectangle to the display area and streams one (address, colour)
// write per pixel towards the display memory write arbiter.
module gci_std_display_rect_fill #(
  parameter int unsigned P_AREA_H     = 640,
  parameter int unsigned P_AREA_V     = 480,
  parameter int unsigned P_AREA_H_N   = 10,
  parameter int unsigned P_AREA_V_N   = 9,
  parameter int unsigned P_MEM_ADDR_N = 23,
  parameter int unsigned P_BASE_ADDR  = 0,
  parameter int unsigned P_COLOR_N    = 24
) (
  input  logic                    iCLOCK,
  input  logic                    iRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iIF_VALID,
  output logic                    oIF_BUSY,
  input  logic                    iIF_MODE,
  input  logic [P_AREA_H_N-1:0]   iIF_X,
  input  logic [P_AREA_V_N-1:0]   iIF_Y,
  input  logic [P_AREA_H_N-1:0]   iIF_WIDTH,
  input  logic [P_AREA_V_N-1:0]   iIF_HEIGHT,
  input  logic [P_COLOR_N-1:0]    iIF_COLOR,
  output logic                    oIF_FINISH,
  output logic                    oIF_VALID,
  input  logic                    iIF_BUSY,
  output logic [P_MEM_ADDR_N-1:0] oIF_ADDR,
  output logic [P_COLOR_N-1:0]    oIF_DATA
);

  // One extra bit on the X/Y arithmetic so X+W style comparisons never overflow
  // and a full-width W/H (mode 1) is always representable.
  localparam int unsigned L_HW = P_AREA_H_N + 1;
  localparam int unsigned L_VW = P_AREA_V_N + 1;

  localparam logic [L_HW-1:0]         L_AREA_H_X = L_HW'(P_AREA_H);
  localparam logic [L_VW-1:0]         L_AREA_V_Y = L_VW'(P_AREA_V);
  localparam logic [P_MEM_ADDR_N-1:0] L_AREA_H_A = P_MEM_ADDR_N'(P_AREA_H);
  localparam logic [P_MEM_ADDR_N-1:0] L_BASE_A   = P_MEM_ADDR_N'(P_BASE_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_FILL  = 2'd2,
    ST_END   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  // Latched command
  logic [L_HW-1:0]         r_x;
  logic [L_VW-1:0]         r_y;
  logic [L_HW-1:0]         r_w;
  logic [L_VW-1:0]         r_h;
  logic [P_COLOR_N-1:0]    r_color;

  // Clipped extent and scan position
  logic [L_HW-1:0]         r_w_eff;
  logic [L_VW-1:0]         r_h_eff;
  logic [L_HW-1:0]         r_col;
  logic [L_VW-1:0]         r_row;
  logic [P_MEM_ADDR_N-1:0] r_row_addr;
  logic [P_MEM_ADDR_N-1:0] r_addr;

  logic                    w_empty;
  logic [L_HW-1:0]         w_room_h;
  logic [L_VW-1:0]         w_room_v;
  logic [L_HW-1:0]         w_w_eff;
  logic [L_VW-1:0]         w_h_eff;
  logic [P_MEM_ADDR_N-1:0] w_start;
  logic                    w_beat;
  logic                    w_col_last;
  logic                    w_row_last;

  // Clipping, start address and beat bookkeeping decoded from the registers.
  always_comb begin
    w_empty    = (r_x >= L_AREA_H_X) || (r_y >= L_AREA_V_Y) ||
                 (r_w == {L_HW{1'b0}}) || (r_h == {L_VW{1'b0}});
    w_room_h   = L_AREA_H_X - r_x;
    w_room_v   = L_AREA_V_Y - r_y;
    w_w_eff    = (r_w < w_room_h) ? r_w : w_room_h;
    w_h_eff    = (r_h < w_room_v) ? r_h : w_room_v;
    w_start    = L_BASE_A + (P_MEM_ADDR_N'(r_y) * L_AREA_H_A) + P_MEM_ADDR_N'(r_x);
    w_beat     = (r_state == ST_FILL) && !iIF_BUSY;
    w_col_last = (r_col == (r_w_eff - L_HW'(1)));
    w_row_last = (r_row == (r_h_eff - L_VW'(1)));
  end

  // State register; either reset returns the engine to IDLE.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_state <= ST_IDLE;
    end else if (iRESET_SYNC) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: IDLE -> SETUP -> FILL (or END if clipped away) -> END -> IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (iIF_VALID) begin
          w_next_state = ST_SETUP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (w_empty) begin
          w_next_state = ST_END;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_FILL: begin
        if (w_beat && w_col_last && w_row_last) begin
          w_next_state = ST_END;
        end else begin
          w_next_state = ST_FILL;
        end
      end
      ST_END: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Command latch, clip/start-address registration and add-only address walk.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      r_x        <= {L_HW{1'b0}};
      r_y        <= {L_VW{1'b0}};
      r_w        <= {L_HW{1'b0}};
      r_h        <= {L_VW{1'b0}};
      r_color    <= {P_COLOR_N{1'b0}};
      r_w_eff    <= {L_HW{1'b0}};
      r_h_eff    <= {L_VW{1'b0}};
      r_col      <= {L_HW{1'b0}};
      r_row      <= {L_VW{1'b0}};
      r_row_addr <= {P_MEM_ADDR_N{1'b0}};
      r_addr     <= {P_MEM_ADDR_N{1'b0}};
    end else if (iRESET_SYNC) begin
      r_x        <= {L_HW{1'b0}};
      r_y        <= {L_VW{1'b0}};
      r_w        <= {L_HW{1'b0}};
      r_h        <= {L_VW{1'b0}};
      r_color    <= {P_COLOR_N{1'b0}};
      r_w_eff    <= {L_HW{1'b0}};
      r_h_eff    <= {L_VW{1'b0}};
      r_col      <= {L_HW{1'b0}};
      r_row      <= {L_VW{1'b0}};
      r_row_addr <= {P_MEM_ADDR_N{1'b0}};
      r_addr     <= {P_MEM_ADDR_N{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (iIF_VALID) begin
            r_color <= iIF_COLOR;
            if (iIF_MODE) begin
              r_x <= {L_HW{1'b0}};
              r_y <= {L_VW{1'b0}};
              r_w <= L_AREA_H_X;
              r_h <= L_AREA_V_Y;
            end else begin
              r_x <= L_HW'(iIF_X);
              r_y <= L_VW'(iIF_Y);
              r_w <= L_HW'(iIF_WIDTH);
              r_h <= L_VW'(iIF_HEIGHT);
            end
          end
        end
        ST_SETUP: begin
          r_w_eff    <= w_w_eff;
          r_h_eff    <= w_h_eff;
          r_col      <= {L_HW{1'b0}};
          r_row      <= {L_VW{1'b0}};
          r_row_addr <= w_start;
          r_addr     <= w_start;
        end
        ST_FILL: begin
          if (w_beat) begin
            if (w_col_last) begin
              if (!w_row_last) begin
                r_col      <= {L_HW{1'b0}};
                r_row      <= r_row + L_VW'(1);
                r_row_addr <= r_row_addr + L_AREA_H_A;
                r_addr     <= r_row_addr + L_AREA_H_A;
              end
            end else begin
              r_col  <= r_col + L_HW'(1);
              r_addr <= r_addr + P_MEM_ADDR_N'(1);
            end
          end
        end
        ST_END: begin
          r_col <= {L_HW{1'b0}};
          r_row <= {L_VW{1'b0}};
        end
        default: begin
          r_col <= {L_HW{1'b0}};
          r_row <= {L_VW{1'b0}};
        end
      endcase
    end
  end

  assign oIF_BUSY   = (r_state != ST_IDLE);
  assign oIF_FINISH = (r_state == ST_END);
  assign oIF_VALID  = w_beat;
  assign oIF_ADDR   = r_addr;
  assign oIF_DATA   = r_color;

endmodule

// File: tb/tb_gci_std_display_rect_fill.sv
// Bench for gci_std_display_rect_fill: directed and randomised commands with
// random downstream stalls, checked against a pixel-list model of the fill.
module tb_gci_std_display_rect_fill;

  localparam int H    = 640;
  localparam int V    = 32;
  localparam int HN   = 10;
  localparam int VN   = 9;
  localparam int AN   = 23;
  localparam int BASE = 0;
  localparam int CN   = 24;

  typedef struct {
    bit             mode;
    int             x;
    int             y;
    int             w;
    int             h;
    logic [CN-1:0]  color;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          srst;
  logic          in_valid;
  logic          in_mode;
  logic [HN-1:0] in_x;
  logic [VN-1:0] in_y;
  logic [HN-1:0] in_w;
  logic [VN-1:0] in_h;
  logic [CN-1:0] in_color;
  logic          in_busy;
  logic          out_busy;
  logic          out_finish;
  logic          out_valid;
  logic [AN-1:0] out_addr;
  logic [CN-1:0] out_data;

  int errors = 0;
  int checks = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  gci_std_display_rect_fill #(
    .P_AREA_H(H), .P_AREA_V(V), .P_AREA_H_N(HN), .P_AREA_V_N(VN),
    .P_MEM_ADDR_N(AN), .P_BASE_ADDR(BASE), .P_COLOR_N(CN)
  ) dut (
    .iCLOCK(clk), .iRESET(rst), .iRESET_SYNC(srst),
    .iIF_VALID(in_valid), .oIF_BUSY(out_busy), .iIF_MODE(in_mode),
    .iIF_X(in_x), .iIF_Y(in_y), .iIF_WIDTH(in_w), .iIF_HEIGHT(in_h),
    .iIF_COLOR(in_color), .oIF_FINISH(out_finish), .oIF_VALID(out_valid),
    .iIF_BUSY(in_busy), .oIF_ADDR(out_addr), .oIF_DATA(out_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input bit m, input int x, input int y, input int w,
                              input int h, input logic [CN-1:0] col);
    cmd_t c;
    c.mode = m; c.x = x; c.y = y; c.w = w; c.h = h; c.color = col;
    return c;
  endfunction

  // Expected pixel addresses, row by row, of the clipped rectangle.
  function automatic void build_model(input cmd_t c);
    int x, y, w, h, we, he;
    exp_q.delete();
    if (c.mode) begin
      x = 0; y = 0; w = H; h = V;
    end else begin
      x = c.x; y = c.y; w = c.w; h = c.h;
    end
    if (x >= H || y >= V || w == 0 || h == 0) return;
    we = (w < H - x) ? w : H - x;
    he = (h < V - y) ? h : V - y;
    for (int r = 0; r < he; r++)
      for (int col = 0; col < we; col++)
        exp_q.push_back(int'(unsigned'(BASE + (y + r) * H + x + col) % (32'd1 << AN)));
  endfunction

  task automatic drive(input cmd_t c);
    in_mode  = c.mode;
    in_x     = HN'(c.x);
    in_y     = VN'(c.y);
    in_w     = HN'(c.w);
    in_h     = VN'(c.h);
    in_color = c.color;
    in_valid = 1'b1;
  endtask

  // Observes one command that was accepted at the edge just before the call.
  task automatic collect(input cmd_t c, input int stall_pct, input bit hold,
                         input cmd_t nxt, input string tag);
    int first_k, last_k, fin_k, viol, addr_err, data_err, busy_err, nbeats, n_exp, limit, exp_fin;
    int unsigned ea;
    build_model(c);
    n_exp = exp_q.size();
    limit = 4 * n_exp + 50;
    first_k = -1; last_k = 0; fin_k = -1;
    viol = 0; addr_err = 0; data_err = 0; busy_err = 0; nbeats = 0;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) drive(nxt);
        else in_valid = 1'b0;
      end
      in_busy = (stall_pct > 0) && (int'($urandom_range(99)) < stall_pct);
      #1;
      if (!out_busy) busy_err++;
      if (out_valid) begin
        nbeats++;
        last_k = k;
        if (first_k < 0) first_k = k;
        if (in_busy) viol++;
        if (exp_q.size() == 0) begin
          addr_err++;
        end else begin
          ea = exp_q.pop_front();
          if (out_addr !== AN'(ea)) addr_err++;
        end
        if (out_data !== c.color) data_err++;
      end
      if (out_finish) begin
        fin_k = k;
        break;
      end
    end
    check({tag, ".finish_seen"}, 64'(fin_k > 0), 64'd1);
    check({tag, ".beats"}, 64'(nbeats), 64'(n_exp));
    check({tag, ".addr_errors"}, 64'(addr_err), 64'd0);
    check({tag, ".data_errors"}, 64'(data_err), 64'd0);
    check({tag, ".valid_while_stalled"}, 64'(viol), 64'd0);
    check({tag, ".busy_dropped"}, 64'(busy_err), 64'd0);
    if (n_exp > 0 && stall_pct == 0) check({tag, ".first_valid_latency"}, 64'(first_k), 64'd2);
    exp_fin = (n_exp == 0) ? 2 : last_k + 1;
    check({tag, ".finish_cycle"}, 64'(fin_k), 64'(exp_fin));
    @(negedge clk);
    in_busy = 1'b0;
    #1;
    check({tag, ".busy_after_finish"}, 64'(out_busy), 64'd0);
    check({tag, ".finish_single"}, 64'(out_finish), 64'd0);
  endtask

  task automatic run_cmd(input cmd_t c, input int stall_pct, input string tag);
    @(negedge clk);
    in_busy = 1'b0;
    drive(c);
    #1;
    check({tag, ".idle_before"}, 64'(out_busy), 64'd0);
    collect(c, stall_pct, 1'b0, c, tag);
  endtask

  task automatic quiet_cycles(input string tag);
    int q_err;
    q_err = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (out_busy || out_valid || out_finish) q_err++;
    end
    check({tag, ".quiet_after_reset"}, 64'(q_err), 64'd0);
  endtask

  initial begin
    cmd_t c, c2;
    int n;
    rst = 1'b1; srst = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_busy = 1'b0;
    in_x = '0; in_y = '0; in_w = '0; in_h = '0; in_color = '0;
    #12;
    check("reset.outputs", 64'({out_busy, out_finish, out_valid, out_addr, out_data}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-screen clear; the rectangle fields are don't-care in mode 1.
    run_cmd(mk(1'b1, 100, 5, 3, 1, 24'h123456), 0, "clear");
    run_cmd(mk(1'b0, 10, 2, 3, 2, 24'hABCDEF), 0, "rect");
    run_cmd(mk(1'b0, H - 2, V - 1, 5, 4, 24'h00FF00), 0, "clip_corner");
    run_cmd(mk(1'b0, H, 0, 4, 4, 24'h0000FF), 0, "empty_x");
    run_cmd(mk(1'b0, 3, V, 4, 4, 24'h0000FE), 0, "empty_y");
    run_cmd(mk(1'b0, 3, 3, 0, 4, 24'h0000FD), 0, "empty_w");
    run_cmd(mk(1'b0, H - 1, V - 1, 1, 1, 24'h777777), 0, "single_pixel");
    run_cmd(mk(1'b0, 0, 0, 4, 1, 24'h112233), 50, "stall");
    run_cmd(mk(1'b0, 5, 1, 900, 2, 24'h445566), 50, "wide_clip");

    // Second command held on the interface during a fill.
    c  = mk(1'b0, 20, 3, 5, 2, 24'hAAAAAA);
    c2 = mk(1'b0, 30, 4, 2, 2, 24'h555555);
    @(negedge clk);
    in_busy = 1'b0;
    drive(c);
    #1;
    check("hold.idle_before", 64'(out_busy), 64'd0);
    collect(c, 0, 1'b1, c2, "hold_first");
    collect(c2, 0, 1'b0, c2, "hold_second");

    // Asynchronous reset between clock edges in the middle of a clear.
    @(negedge clk);
    drive(mk(1'b1, 0, 0, 0, 0, 24'h0F0F0F));
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_busy = 1'b0;
    end
    #1;
    check("async_rst.mid_fill", 64'(out_valid), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst.outputs", 64'({out_busy, out_finish, out_valid, out_addr, out_data}), 64'd0);
    #1 rst = 1'b0;
    quiet_cycles("async_rst");
    run_cmd(mk(1'b0, 10, 2, 3, 2, 24'h13579B), 0, "after_async_rst");

    // Synchronous reset after 100 beats.
    @(negedge clk);
    drive(mk(1'b0, 0, 0, H, V, 24'h2468AC));
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_busy = 1'b0;
      #1;
      if (out_valid) n++;
      if (n == 100) break;
    end
    check("sync_rst.beats_before", 64'(n), 64'd100);
    @(negedge clk);
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("sync_rst.outputs", 64'({out_busy, out_finish, out_valid, out_addr, out_data}), 64'd0);
    quiet_cycles("sync_rst");
    run_cmd(mk(1'b0, 7, 6, 4, 3, 24'hFEDCBA), 0, "after_sync_rst");

    // Random rectangles, some partly or fully off-screen, with random stalls.
    for (int i = 0; i < 8; i++) begin
      c = mk(1'b0, int'($urandom_range(660)), int'($urandom_range(V + 3)),
             int'($urandom_range(24)), int'($urandom_range(5)), CN'($urandom));
      run_cmd(c, 50, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
